contador_sin_dec: RTL and testbench

Synchronous programmable down-counter, the decrementing counterpart of the team's 3-bit up-counter. It loads a start value, counts down to zero on enabled cycles, and flags terminal count. It can stop at zero or auto-reload. It provides timeouts and delay countdowns for the board-level designs.

---
 rtl/contador_sin_dec.sv | 73 +++++++
 tb/tb_contador_sin_dec.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/contador_sin_dec.sv
// Programmable down-counter with terminal-count pulse, stop-at-zero or auto-reload.
// Build option: define CONTADOR_DEC_ACTIVE_LOW_OUT_EN to drive count inverted (active-low LEDs).
module contador_sin_dec #(
   parameter int WIDTH        = 3,
   parameter int RESET_RELOAD = 7
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             en,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] reload;
   logic             tc_r;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         cnt    <= '0;
         reload <= WIDTH'(RESET_RELOAD);
         state  <= IDLE;
         tc_r   <= 1'b0;
      end else begin
         tc_r <= 1'b0;
         if (load) begin
            cnt    <= load_val;
            reload <= load_val;
            state  <= (load_val != '0) ? RUN : DONE;
         end else if (start && state != RUN) begin
            cnt   <= reload;
            state <= (reload != '0) ? RUN : DONE;
         end else if (state == RUN) begin
            // Zero in RUN only persists in auto-reload mode; it is the wrap cycle.
            if (cnt == '0) begin
               if (!auto_reload)
                  state <= DONE;
               else if (en)
                  cnt <= reload;
            end else if (en) begin
               if (cnt == WIDTH'(1)) begin
                  cnt  <= '0;
                  tc_r <= 1'b1;
                  if (!auto_reload)
                     state <= DONE;
               end else begin
                  cnt <= cnt - WIDTH'(1);
               end
            end
         end
      end
   end

`ifdef CONTADOR_DEC_ACTIVE_LOW_OUT_EN
   assign count = ~cnt;
`else
   assign count = cnt;
`endif

   assign tc   = tc_r;
   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_contador_sin_dec.sv
// Table-driven bench for contador_sin_dec (WIDTH=3), plus hand sequences for reset glitching.
module tb_contador_sin_dec;

   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rstn = 1'b1;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic         start = 1'b0;
   logic         en = 1'b0;
   logic         auto_reload = 1'b0;
   logic [W-1:0] count;
   logic         tc, busy, done;

   int checks = 0;
   int failures = 0;

   contador_sin_dec #(.WIDTH(W), .RESET_RELOAD(7)) dut (
      .clk(clk), .rstn(rstn), .load(load), .load_val(load_val), .start(start),
      .en(en), .auto_reload(auto_reload), .count(count), .tc(tc), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         rstn, load;
      logic [W-1:0] lv;
      logic         start, en, ar;
      logic [W-1:0] e_cnt;
      logic         e_tc;
      logic         chk_st;
      logic         e_busy, e_done;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [W-1:0] port_val(input logic [W-1:0] v);
`ifdef CONTADOR_DEC_ACTIVE_LOW_OUT_EN
      return ~v;
`else
      return v;
`endif
   endfunction

   task automatic add(input logic r, input logic l, input int lv, input logic s, input logic e,
                      input logic ar, input int ec, input logic et, input logic cs,
                      input logic eb, input logic ed);
      vec_t v;
      v.rstn = r; v.load = l; v.lv = W'(lv); v.start = s; v.en = e; v.ar = ar;
      v.e_cnt = W'(ec); v.e_tc = et; v.chk_st = cs; v.e_busy = eb; v.e_done = ed;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input logic [W-1:0] ec, input logic et,
                                input logic cs, input logic eb, input logic ed);
      check({tag, " count"}, int'(count), int'(port_val(ec)));
      check({tag, " tc"}, int'(tc), int'(et));
      if (cs) begin
         check({tag, " busy"}, int'(busy), int'(eb));
         check({tag, " done"}, int'(done), int'(ed));
      end
   endtask

   initial begin
      //   rstn ld lv st en ar  cnt tc chk busy done
      // reset held for two edges while load is asserted
      add(0, 1, 5, 0, 0, 0,   0, 0, 1, 0, 0);
      add(0, 1, 5, 0, 0, 0,   0, 0, 1, 0, 0);
      // one-shot from 5
      add(1, 1, 5, 0, 0, 0,   5, 0, 1, 1, 0);
      add(1, 0, 0, 0, 1, 0,   4, 0, 1, 1, 0);
      add(1, 0, 0, 0, 1, 0,   3, 0, 1, 1, 0);
      add(1, 0, 0, 0, 1, 0,   2, 0, 1, 1, 0);
      add(1, 0, 0, 0, 1, 0,   1, 0, 1, 1, 0);
      add(1, 0, 0, 0, 1, 0,   0, 1, 0, 0, 0);
      add(1, 0, 0, 0, 1, 0,   0, 0, 1, 0, 1);
      add(1, 0, 0, 0, 1, 0,   0, 0, 1, 0, 1);
      // auto-reload from 3
      add(1, 1, 3, 0, 0, 1,   3, 0, 1, 1, 0);
      add(1, 0, 0, 0, 1, 1,   2, 0, 1, 1, 0);
      add(1, 0, 0, 0, 1, 1,   1, 0, 1, 1, 0);
      add(1, 0, 0, 0, 1, 1,   0, 1, 1, 1, 0);
      add(1, 0, 0, 0, 1, 1,   3, 0, 1, 1, 0);
      add(1, 0, 0, 0, 1, 1,   2, 0, 1, 1, 0);
      add(1, 0, 0, 0, 1, 1,   1, 0, 1, 1, 0);
      add(1, 0, 0, 0, 1, 1,   0, 1, 1, 1, 0);
      add(1, 0, 0, 0, 1, 1,   3, 0, 1, 1, 0);
      // enable gating from 6
      add(1, 1, 6, 0, 0, 0,   6, 0, 1, 1, 0);
      add(1, 0, 0, 0, 1, 0,   5, 0, 1, 1, 0);
      add(1, 0, 0, 0, 0, 0,   5, 0, 1, 1, 0);
      add(1, 0, 0, 0, 0, 0,   5, 0, 1, 1, 0);
      add(1, 0, 0, 0, 1, 0,   4, 0, 1, 1, 0);
      add(1, 0, 0, 0, 1, 0,   3, 0, 1, 1, 0);
      // priority: load beats start and en, then mid-run reset restores reload=7
      add(1, 1, 4, 0, 0, 0,   4, 0, 1, 1, 0);
      add(1, 1, 2, 1, 1, 0,   2, 0, 1, 1, 0);
      add(1, 0, 0, 0, 1, 0,   1, 0, 1, 1, 0);
      add(0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 0);
      add(1, 0, 0, 0, 1, 0,   0, 0, 1, 0, 0);
      add(1, 0, 0, 1, 0, 0,   7, 0, 1, 1, 0);
      add(1, 0, 0, 0, 1, 0,   6, 0, 1, 1, 0);
      // start ignored in RUN
      add(1, 0, 0, 1, 0, 0,   6, 0, 1, 1, 0);
      // load 0 goes straight to DONE; start with reload 0 stays DONE
      add(1, 1, 0, 0, 0, 0,   0, 0, 1, 0, 1);
      add(1, 0, 0, 1, 1, 0,   0, 0, 1, 0, 1);
      // auto-reload at zero: en=0 holds, dropping auto_reload goes DONE
      add(1, 1, 1, 0, 0, 1,   1, 0, 1, 1, 0);
      add(1, 0, 0, 0, 1, 1,   0, 1, 1, 1, 0);
      add(1, 0, 0, 0, 0, 1,   0, 0, 1, 1, 0);
      add(1, 0, 0, 0, 1, 0,   0, 0, 1, 0, 1);
      // DONE left via start using reload=1
      add(1, 0, 0, 1, 0, 0,   1, 0, 1, 1, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         rstn = vecs[i].rstn; load = vecs[i].load; load_val = vecs[i].lv;
         start = vecs[i].start; en = vecs[i].en; auto_reload = vecs[i].ar;
         @(posedge clk);
         #1;
         check_outputs($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_tc,
                       vecs[i].chk_st, vecs[i].e_busy, vecs[i].e_done);
      end

      // rstn pulsed low only between edges must not reset
      @(negedge clk);
      rstn = 1; load = 1; load_val = 5; start = 0; en = 0; auto_reload = 0;
      @(posedge clk);
      #1;
      check_outputs("glitch_load", 3'd5, 1'b0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      load = 0;
      rstn = 0;
      #2;
      rstn = 1;
      @(posedge clk);
      #1;
      check_outputs("glitch_hold", 3'd5, 1'b0, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      en = 1;
      @(posedge clk);
      #1;
      check_outputs("glitch_dec", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
